// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, memory wait, taken-branch squash and halt drain.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmemREN_out_3,
  input  logic        dmemWEN_out_3,
  input  logic        MemRead_out_2,
  input  logic [4:0]  wsel_out_2,
  input  logic [4:0]  rs_out_1,
  input  logic [4:0]  rt_out_1,
  input  logic        uses_rt_1,
  input  logic        PCSrc_out_3,
  input  logic        halt_out_4,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDwait = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;
  logic   r_run_ok;

  logic w_access;
  logic w_lvl_halt;
  logic w_lvl_dwait;
  logic w_lvl_branch;
  logic w_loaduse;
  logic w_active;

  assign w_access   = dmemREN_out_3 | dmemWEN_out_3;
  assign w_loaduse  = MemRead_out_2 && (wsel_out_2 != 5'd0) &&
                      ((wsel_out_2 == rs_out_1) || (uses_rt_1 && (wsel_out_2 == rt_out_1)));

  // Outputs stay quiet during reset and until the first edge after release.
  assign w_active     = r_run_ok && !RST;
  assign w_lvl_halt   = (r_state == StHalt) || halt_out_4;
  assign w_lvl_dwait  = (w_access || (r_state == StDwait)) && !dhit;
  assign w_lvl_branch = w_active && !w_lvl_halt && !w_lvl_dwait && PCSrc_out_3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= StRun;
      r_run_ok <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_run_ok <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (halt_out_4) begin
      w_state_next = StHalt;
    end else begin
      unique case (r_state)
        StRun:   if (w_access && !dhit) w_state_next = StDwait;
        StDwait: if (dhit) w_state_next = StRun;
        StHalt:  w_state_next = StHalt;
        default: w_state_next = StRun;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    if (w_active) begin
      if (w_lvl_halt) begin
        halted = 1'b1;
      end else if (w_lvl_dwait) begin
        // Full freeze; a pending branch waits for the access to complete.
      end else if (w_lvl_branch) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (w_loaduse) begin
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else if (!ihit) begin
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = w_active && !pc_en && (r_state != StHalt);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall_evt) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_lvl_branch) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
